// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants and types for the vscale data-memory responder:
// memory access-size encodings, FSM states and the byte-merge helper.
package vscale_dmem_responder_pkg;

    localparam int XPR_LEN             = 32;
    localparam int MEM_TYPE_WIDTH      = 3;
    localparam int DMEM_WAIT_CNT_WIDTH = 4;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB  = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH  = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW  = 3'd2;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SBU = 3'd4;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SHU = 3'd5;

    typedef enum logic [1:0] {
        DMEM_STATE_IDLE = 2'd0,
        DMEM_STATE_WAIT = 2'd1,
        DMEM_STATE_DATA = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic       wen;
        logic       bad;
        logic [3:0] be;
    } dmem_req_t;

    // Lanes with their enable set come from newWord, the rest keep oldWord.
    function automatic logic [XPR_LEN-1:0] byteMerge(input logic [XPR_LEN-1:0] oldWord,
                                                     input logic [XPR_LEN-1:0] newWord,
                                                     input logic [3:0]         be);
        logic [XPR_LEN-1:0] merged;
        merged = oldWord;
        for (int lane = 0; lane < 4; lane++) begin
            if (be[lane]) begin
                merged[lane*8 +: 8] = newWord[lane*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/vscale_dmem_responder_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
interface vscale_dmem_responder_if;
    import vscale_dmem_responder_pkg::*;

    logic                      dmem_en;
    logic                      dmem_wen;
    logic [MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [XPR_LEN-1:0]        dmem_addr;
    logic [XPR_LEN-1:0]        dmem_wdata_delayed;
    logic                      dmem_wait;
    logic [XPR_LEN-1:0]        dmem_rdata;
    logic                      dmem_badmem_e;

    modport master (
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        input  dmem_wait, dmem_rdata, dmem_badmem_e
    );

    modport slave (
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        output dmem_wait, dmem_rdata, dmem_badmem_e
    );

endinterface

// File: rtl/vscale_dmem_responder_byte_lane.sv
// Decodes access size and low address bits into byte enables and a
// misalignment flag.
module vscale_dmem_responder_byte_lane
    import vscale_dmem_responder_pkg::*;
(
    input  logic [MEM_TYPE_WIDTH-1:0] size_i,
    input  logic [1:0]                addrLo_i,
    output logic [3:0]                be_o,
    output logic                      misaligned_o
);

    // Unknown size codes produce no byte enables and are reported as bad.
    always_comb begin
        be_o         = 4'h0;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_TYPE_SB, MEM_TYPE_SBU: begin
                be_o = 4'b0001 << addrLo_i;
            end
            MEM_TYPE_SH, MEM_TYPE_SHU: begin
                be_o         = 4'b0011 << addrLo_i;
                misaligned_o = addrLo_i[0];
            end
            MEM_TYPE_SW: begin
                be_o         = 4'hF;
                misaligned_o = (addrLo_i != 2'b00);
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Word-addressed SRAM responder for the vscale data-memory port with
// programmable wait states, bad-access flagging and store-to-load forwarding.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    vscale_dmem_responder_if.slave dmem
);

    localparam int                             IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0]                    MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [DMEM_WAIT_CNT_WIDTH-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_CNT_WIDTH'(WAIT_CYCLES - 1);

    logic [XPR_LEN-1:0] mem [MEM_WORDS];

    dmem_state_e                    state_q, state_d;
    logic [DMEM_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    dmem_req_t                      req_q, req_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [XPR_LEN-1:0]             rdata_q, rdata_d;

    logic [3:0]         laneBe;
    logic               laneMisaligned;
    logic [XPR_LEN-1:0] offset;
    logic               inRange;
    dmem_req_t          inReq;
    logic               accept;
    logic               commit;
    logic [XPR_LEN-1:0] readWord;

    vscale_dmem_responder_byte_lane u_byteLane (
        .size_i       (dmem.dmem_size),
        .addrLo_i     (dmem.dmem_addr[1:0]),
        .be_o         (laneBe),
        .misaligned_o (laneMisaligned)
    );

    // Range check uses the full offset so addresses past the array never wrap onto it.
    assign offset  = dmem.dmem_addr - BASE_ADDR;
    assign inRange = (dmem.dmem_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);

    assign inReq.wen = dmem.dmem_wen;
    assign inReq.bad = laneMisaligned || !inRange;
    assign inReq.be  = laneBe;

    assign accept = dmem.dmem_en && (state_q != DMEM_STATE_WAIT);
    assign commit = (state_q == DMEM_STATE_DATA) && req_q.wen && !req_q.bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DMEM_STATE_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        if (accept) begin
            req_d = inReq;
            idx_d = offset[IDX_W+1:2];
            if (WAIT_CYCLES == 0) begin
                state_d = DMEM_STATE_DATA;
            end else begin
                state_d = DMEM_STATE_WAIT;
                cnt_d   = WAIT_INIT;
            end
        end else begin
            case (state_q)
                DMEM_STATE_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = DMEM_STATE_DATA;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = DMEM_STATE_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dmem.dmem_wait     = (state_q == DMEM_STATE_WAIT);
        dmem.dmem_badmem_e = (state_q == DMEM_STATE_DATA) && req_q.bad;
        dmem.dmem_rdata    = rdata_q;
    end

    // A store closing on the same edge as a load's read is merged in, so the load sees it.
    always_comb begin
        readWord = mem[idx_d];
        if (commit && (idx_q == idx_d)) begin
            readWord = byteMerge(readWord, dmem.dmem_wdata_delayed, req_q.be);
        end
        rdata_d = rdata_q;
        if ((state_d == DMEM_STATE_DATA) && !req_d.wen) begin
            rdata_d = req_d.bad ? '0 : readWord;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= byteMerge(mem[idx_q], dmem.dmem_wdata_delayed, req_q.be);
        end
    end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Self-checking bench for vscale_dmem_responder: directed vector table on a
// zero-wait instance, wait-state and reset sequences, and a random stream.
module tb_vscale_dmem_responder;
    import vscale_dmem_responder_pkg::*;

    typedef struct {
        logic        en;
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expWait;
        logic        expBad;
        logic [31:0] expRdata;
    } vec_t;

    logic clk;
    logic reset;
    int   passCount;
    int   checkCount;
    vec_t vecs[16];
    logic [31:0] shadow[8];

    vscale_dmem_responder_if bus0 ();
    vscale_dmem_responder_if bus3 ();

    vscale_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .dmem  (bus0.slave)
    );

    vscale_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .dmem  (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus0(input logic en, input logic wen, input logic [2:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        bus0.dmem_en            = en;
        bus0.dmem_wen           = wen;
        bus0.dmem_size          = size;
        bus0.dmem_addr          = addr;
        bus0.dmem_wdata_delayed = wdata;
    endtask

    task automatic applyStimulus3(input logic en, input logic wen, input logic [2:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        bus3.dmem_en            = en;
        bus3.dmem_wen           = wen;
        bus3.dmem_size          = size;
        bus3.dmem_addr          = addr;
        bus3.dmem_wdata_delayed = wdata;
    endtask

    // One cycle on the WAIT_CYCLES=3 instance: drive after the edge, check at the falling edge.
    task automatic step3(input string name, input logic en, input logic wen, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic expWait, input logic expBad, input logic [31:0] expRdata);
        @(posedge clk);
        #1;
        applyStimulus3(en, wen, size, addr, wdata);
        @(negedge clk);
        checkOutput({name, ".wait"}, 32'(bus3.dmem_wait), 32'(expWait));
        checkOutput({name, ".bad"}, 32'(bus3.dmem_badmem_e), 32'(expBad));
        checkOutput({name, ".rdata"}, bus3.dmem_rdata, expRdata);
    endtask

    function automatic logic [3:0] beOf(input logic [2:0] size, input logic [1:0] lo);
        if (size == MEM_TYPE_SB) return 4'b0001 << lo;
        if (size == MEM_TYPE_SH) return 4'b0011 << lo;
        return 4'hF;
    endfunction

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        applyStimulus0(1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0);
        applyStimulus3(1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0);

        //                en  wen  size         addr        wdata         wait bad  rdata
        vecs[0]  = '{1'b1, 1'b1, MEM_TYPE_SW, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, MEM_TYPE_SW, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, MEM_TYPE_SW, 32'h100, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, MEM_TYPE_SB, 32'h102, 32'h11223344, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, MEM_TYPE_SW, 32'h100, 32'hAAAAAAAA, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b1, MEM_TYPE_SH, 32'h101, 32'h0,        1'b0, 1'b0, 32'h11AA3344};
        vecs[6]  = '{1'b1, 1'b0, MEM_TYPE_SW, 32'h102, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h11AA3344};
        vecs[7]  = '{1'b1, 1'b0, MEM_TYPE_SW, 32'h100, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, MEM_TYPE_SW, 32'h1000, 32'h0,       1'b0, 1'b0, 32'h11AA3344};
        vecs[9]  = '{1'b1, 1'b1, MEM_TYPE_SW, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, MEM_TYPE_SW, 32'hFFC, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, MEM_TYPE_SH, 32'hFFE, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 1'b0, MEM_TYPE_SW, 32'h0,   32'h55555555, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[13] = '{1'b1, 1'b0, MEM_TYPE_SW, 32'hFFC, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vecs[14] = '{1'b0, 1'b0, MEM_TYPE_SW, 32'h0,   32'h0,        1'b0, 1'b0, 32'h5555F00D};
        vecs[15] = '{1'b0, 1'b0, MEM_TYPE_SW, 32'h0,   32'h0,        1'b0, 1'b0, 32'h5555F00D};

        #12;
        checkOutput("reset.dut0.wait", 32'(bus0.dmem_wait), 32'd0);
        checkOutput("reset.dut0.bad", 32'(bus0.dmem_badmem_e), 32'd0);
        checkOutput("reset.dut0.rdata", bus0.dmem_rdata, 32'h0);
        checkOutput("reset.dut3.wait", 32'(bus3.dmem_wait), 32'd0);
        checkOutput("reset.dut3.rdata", bus3.dmem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, one per cycle; expectations describe the access issued one row earlier.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            applyStimulus0(vecs[i].en, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.wait", i), 32'(bus0.dmem_wait), 32'(vecs[i].expWait));
            checkOutput($sformatf("vec%0d.bad", i), 32'(bus0.dmem_badmem_e), 32'(vecs[i].expBad));
            checkOutput($sformatf("vec%0d.rdata", i), bus0.dmem_rdata, vecs[i].expRdata);
        end

        // Wait states: store then load, with the request held through the stall.
        step3("w3.sw.addr", 1'b1, 1'b1, MEM_TYPE_SW, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step3($sformatf("w3.sw.stall%0d", i), 1'b1, 1'b1, MEM_TYPE_SW, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        step3("w3.sw.data", 1'b1, 1'b0, MEM_TYPE_SW, 32'h200, 32'h12345678, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step3($sformatf("w3.lw.stall%0d", i), 1'b1, 1'b0, MEM_TYPE_SW, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        step3("w3.lw.data", 1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678);
        step3("w3.idle", 1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678);

        // Asynchronous reset in the middle of a stalled store.
        step3("rst.sw.addr", 1'b1, 1'b1, MEM_TYPE_SW, 32'h200, 32'h0, 1'b0, 1'b0, 32'h12345678);
        step3("rst.sw.stall", 1'b1, 1'b1, MEM_TYPE_SW, 32'h200, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst.async.wait", 32'(bus3.dmem_wait), 32'd0);
        checkOutput("rst.async.bad", 32'(bus3.dmem_badmem_e), 32'd0);
        checkOutput("rst.async.rdata", bus3.dmem_rdata, 32'h0);
        applyStimulus3(1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step3("rst.lw.addr", 1'b1, 1'b0, MEM_TYPE_SW, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step3($sformatf("rst.lw.stall%0d", i), 1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step3("rst.lw.data", 1'b0, 1'b0, MEM_TYPE_SW, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678);

        // Random back-to-back stream over eight words, against a word-wide shadow.
        begin
            logic        prevValid, prevWen, prevBad;
            logic [31:0] prevWdata, prevExp;
            prevValid = 1'b0;
            prevWen   = 1'b0;
            prevBad   = 1'b0;
            prevWdata = 32'h0;
            prevExp   = 32'h0;
            for (int n = 0; n <= 300; n++) begin
                logic        en, wen, bad;
                logic [2:0]  size;
                logic [1:0]  lo;
                logic [31:0] addr, wdata, r;
                int          w;
                en    = (n < 300);
                w     = (n < 8) ? n : int'($urandom_range(0, 7));
                wen   = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
                size  = (n < 8) ? MEM_TYPE_SW : 3'($urandom_range(0, 2));
                r     = $urandom;
                lo    = 2'b00;
                bad   = 1'b0;
                if (size == MEM_TYPE_SB) lo = 2'($urandom_range(0, 3));
                if (size == MEM_TYPE_SH) lo = {1'($urandom_range(0, 1)), 1'b0};
                addr  = 32'h300 + 32'(w * 4);
                if (n >= 8 && $urandom_range(0, 9) == 0) begin
                    bad = 1'b1;
                    if (size == MEM_TYPE_SB) addr = 32'h1000 + 32'(w * 4);
                    else lo = 2'b01;
                end
                addr  = addr + 32'(lo);
                wdata = (size == MEM_TYPE_SB) ? {4{r[7:0]}} :
                        (size == MEM_TYPE_SH) ? {2{r[15:0]}} : r;

                @(posedge clk);
                #1;
                applyStimulus0(en, wen, size, addr, prevWdata);
                @(negedge clk);
                if (prevValid) begin
                    checkOutput($sformatf("rnd%0d.bad", n - 1), 32'(bus0.dmem_badmem_e), 32'(prevBad));
                    if (!prevWen && !prevBad)
                        checkOutput($sformatf("rnd%0d.rdata", n - 1), bus0.dmem_rdata, prevExp);
                end

                if (en && wen && !bad) begin
                    for (int lane = 0; lane < 4; lane++)
                        if (beOf(size, lo)[lane]) shadow[w][lane*8 +: 8] = wdata[lane*8 +: 8];
                end
                prevValid = en;
                prevWen   = wen;
                prevBad   = bad;
                prevWdata = wdata;
                prevExp   = bad ? 32'h0 : shadow[w];
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
